// File: rtl/bird_flight_ctrl_if.sv
// bird_flight_ctrl_if: game-control side and drawing-object side of the bird
// motion controller, bundled into one interface.
// master = game-control logic / stimulus, slave = bird_flight_ctrl.
interface bird_flight_ctrl_if;
  logic               startOfFrame;
  logic               launch;
  logic signed [10:0] speedXIn;
  logic signed [10:0] speedYIn;
  logic               collision;
  logic               resetBird;
  logic signed [10:0] topLeftX;
  logic signed [10:0] topLeftY;
  logic               flying;
  logic               landed;
  logic [1:0]         state;

  modport master (
    output startOfFrame, launch, speedXIn, speedYIn, collision, resetBird,
    input  topLeftX, topLeftY, flying, landed, state
  );

  modport slave (
    input  startOfFrame, launch, speedXIn, speedYIn, collision, resetBird,
    output topLeftX, topLeftY, flying, landed, state
  );
endinterface

// File: rtl/bird_flight_ctrl.sv
// bird_flight_ctrl: per-frame motion controller for the launched bird sprite.
// Position is kept in pixel*16 fixed point; velocities are in 1/16 px/frame.
// Optional feature macro: BIRD_BOUNCE_EN (ground hits bounce instead of stopping).
module bird_flight_ctrl #(
  parameter int INIT_X          = 64,
  parameter int INIT_Y          = 380,
  parameter int OBJECT_WIDTH_X  = 32,
  parameter int OBJECT_HEIGHT_Y = 32,
  parameter int SCREEN_W        = 640,
  parameter int GROUND_Y        = 440,
  parameter int GRAVITY         = 8,
  parameter int MAX_SPEED       = 512
) (
  input  logic           clk,
  input  logic           resetN,
  bird_flight_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FLIGHT  = 2'd1,
    STOPPED = 2'd2
  } state_t;

  localparam logic signed [15:0] INIT_X_FP   = 16'(INIT_X * 16);
  localparam logic signed [15:0] INIT_Y_FP   = 16'(INIT_Y * 16);
  localparam logic signed [15:0] GROUND_FP   = 16'((GROUND_Y - OBJECT_HEIGHT_Y) * 16);
  localparam logic signed [15:0] RIGHT_FP    = 16'((SCREEN_W - OBJECT_WIDTH_X) * 16);
  localparam logic signed [16:0] GROUND_PX   = 17'(GROUND_Y - OBJECT_HEIGHT_Y);
  localparam logic signed [16:0] RIGHT_PX    = 17'(SCREEN_W - OBJECT_WIDTH_X);
  localparam logic signed [12:0] GRAV13      = 13'(GRAVITY);
  localparam logic signed [12:0] VMAX13      = 13'(MAX_SPEED);
  localparam logic signed [12:0] VMIN13      = 13'(-MAX_SPEED);
  localparam logic signed [11:0] VMAX12      = 12'(MAX_SPEED);
  localparam logic signed [11:0] VMIN12      = 12'(-MAX_SPEED);
  localparam logic signed [10:0] INIT_X_PX   = 11'(INIT_X);
  localparam logic signed [10:0] INIT_Y_PX   = 11'(INIT_Y);
`ifdef BIRD_BOUNCE_EN
  localparam logic signed [11:0] BOUNCE_MIN  = 12'(2 * GRAVITY);
  localparam logic signed [11:0] BOUNCE_MINN = 12'(-2 * GRAVITY);
`endif

  state_t             state_q, state_d;
  logic signed [15:0] x_pos_q, x_pos_d, y_pos_q, y_pos_d;
  logic signed [11:0] vx_q, vx_d, vy_q, vy_d;
  logic               collision_latch_q, collision_latch_d;
  logic signed [10:0] top_left_x_q, top_left_x_d, top_left_y_q, top_left_y_d;
  logic               flying_q, flying_d, landed_q, landed_d;

  // Frame-update intermediates
  logic signed [12:0] vy_sum, vx_ext;
  logic signed [11:0] vy_grav, vx_half, vx_coll, vx_step;
  logic signed [16:0] x_new, y_new, x_new_px, y_new_px;
  logic signed [15:0] x_fin, y_fin;
  logic               hit_ground, hit_left, hit_right;
`ifdef BIRD_BOUNCE_EN
  logic signed [11:0] vy_bounce, vx_bounce;
`endif

  // Clamp a widened velocity to +/-MAX_SPEED.
  function automatic logic signed [11:0] sat_speed(input logic signed [12:0] v);
    logic signed [11:0] r;
    if (v > VMAX13)      r = VMAX12;
    else if (v < VMIN13) r = VMIN12;
    else                 r = v[11:0];
    return r;
  endfunction

  // Next-state, frame physics and output computation.
  always_comb begin
    state_d           = state_q;
    x_pos_d           = x_pos_q;
    y_pos_d           = y_pos_q;
    vx_d              = vx_q;
    vy_d              = vy_q;
    collision_latch_d = collision_latch_q;

    // Gravity first, then collision rebound on the horizontal speed.
    vy_sum  = {vy_q[11], vy_q};
    vy_sum  = vy_sum + GRAV13;
    vy_grav = sat_speed(vy_sum);
    vx_half = vx_q >>> 1;
    vx_coll = (collision_latch_q || bus.collision) ? -vx_half : vx_q;
    vx_ext  = {vx_coll[11], vx_coll};
    vx_step = sat_speed(vx_ext);

    // Move with the new velocities, then test the new rectangle against the edges.
    x_new    = {x_pos_q[15], x_pos_q} + {{5{vx_step[11]}}, vx_step};
    y_new    = {y_pos_q[15], y_pos_q} + {{5{vy_grav[11]}}, vy_grav};
    x_new_px = x_new >>> 4;
    y_new_px = y_new >>> 4;
    hit_ground = (y_new_px >= GROUND_PX);
    hit_left   = x_new[16];
    hit_right  = (x_new_px > RIGHT_PX);
    x_fin = x_new[15:0];
    if (hit_left)       x_fin = '0;
    else if (hit_right) x_fin = RIGHT_FP;
    y_fin = hit_ground ? GROUND_FP : y_new[15:0];
`ifdef BIRD_BOUNCE_EN
    vy_bounce = -(vy_grav >>> 1);
    vx_bounce = vx_step - (vx_step >>> 2);
`endif

    case (state_q)
      IDLE: begin
        x_pos_d = INIT_X_FP;
        y_pos_d = INIT_Y_FP;
        if (bus.launch) begin
          vx_d              = {bus.speedXIn[10], bus.speedXIn};
          vy_d              = {bus.speedYIn[10], bus.speedYIn};
          collision_latch_d = 1'b0;
          state_d           = FLIGHT;
        end
      end
      FLIGHT: begin
        if (bus.startOfFrame) begin
          collision_latch_d = 1'b0;
          x_pos_d           = x_fin;
          y_pos_d           = y_fin;
          vx_d              = vx_step;
          vy_d              = vy_grav;
`ifdef BIRD_BOUNCE_EN
          if (hit_left || hit_right) begin
            vx_d    = '0;
            vy_d    = '0;
            state_d = STOPPED;
          end else if (hit_ground) begin
            if ((vy_bounce > BOUNCE_MINN) && (vy_bounce < BOUNCE_MIN)) begin
              vx_d    = '0;
              vy_d    = '0;
              state_d = STOPPED;
            end else begin
              vx_d = vx_bounce;
              vy_d = vy_bounce;
            end
          end
`else
          if (hit_ground || hit_left || hit_right) begin
            vx_d    = '0;
            vy_d    = '0;
            state_d = STOPPED;
          end
`endif
        end else if (bus.collision) begin
          collision_latch_d = 1'b1;
        end
      end
      STOPPED: begin
      end
      default: state_d = IDLE;
    endcase

    // Return to rest overrides everything else in the same cycle.
    if (bus.resetBird) begin
      state_d           = IDLE;
      x_pos_d           = INIT_X_FP;
      y_pos_d           = INIT_Y_FP;
      vx_d              = '0;
      vy_d              = '0;
      collision_latch_d = 1'b0;
    end

    top_left_x_d = x_pos_d[14:4];
    top_left_y_d = y_pos_d[14:4];
    flying_d     = (state_d == FLIGHT);
    landed_d     = (state_d == STOPPED) && (state_q != STOPPED);
  end

  // State, motion and registered output flops.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state_q           <= IDLE;
      x_pos_q           <= '0;
      y_pos_q           <= '0;
      vx_q              <= '0;
      vy_q              <= '0;
      collision_latch_q <= 1'b0;
      top_left_x_q      <= INIT_X_PX;
      top_left_y_q      <= INIT_Y_PX;
      flying_q          <= 1'b0;
      landed_q          <= 1'b0;
    end else begin
      state_q           <= state_d;
      x_pos_q           <= x_pos_d;
      y_pos_q           <= y_pos_d;
      vx_q              <= vx_d;
      vy_q              <= vy_d;
      collision_latch_q <= collision_latch_d;
      top_left_x_q      <= top_left_x_d;
      top_left_y_q      <= top_left_y_d;
      flying_q          <= flying_d;
      landed_q          <= landed_d;
    end
  end

  assign bus.topLeftX = top_left_x_q;
  assign bus.topLeftY = top_left_y_q;
  assign bus.flying   = flying_q;
  assign bus.landed   = landed_q;
  assign bus.state    = state_q;

endmodule

// File: tb/tb_bird_flight_ctrl.sv
// tb_bird_flight_ctrl: randomized and directed flights of bird_flight_ctrl,
// compared cycle by cycle against an integer model of the motion rules.
module tb_bird_flight_ctrl;
  localparam int INIT_X          = 64;
  localparam int INIT_Y          = 380;
  localparam int OBJECT_WIDTH_X  = 32;
  localparam int OBJECT_HEIGHT_Y = 32;
  localparam int SCREEN_W        = 640;
  localparam int GROUND_Y        = 440;
  localparam int GRAVITY         = 8;
  localparam int MAX_SPEED       = 512;

  logic clk = 1'b0;
  logic resetN;
  bird_flight_ctrl_if bus ();

  bird_flight_ctrl dut (
    .clk   (clk),
    .resetN(resetN),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int landed_count = 0;

  // Model state: positions in 1/16 px, state as 0/1/2.
  int m_state, m_x, m_y, m_vx, m_vy;
  bit m_latch, m_landed;

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int floordiv(input int a, input int b);
    if (a >= 0) return a / b;
    return -((-a + b - 1) / b);
  endfunction

  function automatic int sat(input int v);
    if (v > MAX_SPEED)  return MAX_SPEED;
    if (v < -MAX_SPEED) return -MAX_SPEED;
    return v;
  endfunction

  task automatic model_home();
    m_state = 0; m_x = INIT_X * 16; m_y = INIT_Y * 16;
    m_vx = 0; m_vy = 0; m_latch = 0; m_landed = 0;
  endtask

  task automatic model_stop();
    m_vx = 0; m_vy = 0; m_state = 2; m_landed = 1;
  endtask

  task automatic model_step(input bit sof, input bit la, input int sx, input int sy,
                            input bit coll, input bit rb);
    int nx, ny, tx, ty;
    bit g, l, r;
    m_landed = 0;
    if (rb) begin
      model_home();
    end else if (m_state == 0) begin
      m_x = INIT_X * 16; m_y = INIT_Y * 16;
      if (la) begin m_vx = sx; m_vy = sy; m_state = 1; m_latch = 0; end
    end else if (m_state == 1) begin
      if (sof) begin
        m_vy = sat(m_vy + GRAVITY);
        if (m_latch || coll) m_vx = -floordiv(m_vx, 2);
        m_vx = sat(m_vx);
        m_latch = 0;
        nx = m_x + m_vx; ny = m_y + m_vy;
        tx = floordiv(nx, 16); ty = floordiv(ny, 16);
        g = (ty + OBJECT_HEIGHT_Y >= GROUND_Y);
        l = (tx < 0);
        r = (tx + OBJECT_WIDTH_X > SCREEN_W);
        if (g) ny = (GROUND_Y - OBJECT_HEIGHT_Y) * 16;
        if (l) nx = 0;
        else if (r) nx = (SCREEN_W - OBJECT_WIDTH_X) * 16;
        m_x = nx; m_y = ny;
`ifdef BIRD_BOUNCE_EN
        if (l || r) model_stop();
        else if (g) begin : bounce
          int bvx, bvy;
          bvy = -floordiv(m_vy, 2);
          bvx = m_vx - floordiv(m_vx, 4);
          if (bvy > -2 * GRAVITY && bvy < 2 * GRAVITY) model_stop();
          else begin m_vx = bvx; m_vy = bvy; end
        end
`else
        if (g || l || r) model_stop();
`endif
      end else if (coll) begin
        m_latch = 1;
      end
    end
  endtask

  task automatic check_outputs();
    check_eq("topLeftX", int'(bus.topLeftX), floordiv(m_x, 16));
    check_eq("topLeftY", int'(bus.topLeftY), floordiv(m_y, 16));
    check_eq("flying",   int'(bus.flying), (m_state == 1) ? 1 : 0);
    check_eq("landed",   int'(bus.landed), m_landed ? 1 : 0);
    check_eq("state",    int'(bus.state), m_state);
  endtask

  // One clock: drive inputs, let the edge pass, advance the model, compare.
  task automatic tick(input bit sof, input bit la, input int sx, input int sy,
                      input bit coll, input bit rb);
    bus.startOfFrame = sof; bus.launch = la;
    bus.speedXIn = 11'(sx); bus.speedYIn = 11'(sy);
    bus.collision = coll; bus.resetBird = rb;
    @(posedge clk);
    model_step(sof, la, sx, sy, coll, rb);
    #1;
    check_outputs();
    if (bus.landed) landed_count++;
  endtask

  // One short video frame: startOfFrame then three quiet cycles.
  task automatic frame(input bit rnd);
    tick(1'b1, 1'b0, 0, 0, rnd && ($urandom_range(0, 7) == 0), 1'b0);
    for (int i = 0; i < 3; i++)
      tick(1'b0, rnd && ($urandom_range(0, 15) == 0), int'($urandom_range(0, 100)), -50,
           rnd && ($urandom_range(0, 5) == 0), 1'b0);
  endtask

  task automatic fly_until_stopped(input bit rnd, output int frames);
    frames = 0;
    while (m_state == 1 && frames < 600) begin
      frame(rnd);
      frames++;
    end
    check_eq("flight_stopped", int'(bus.state), 2);
  endtask

  initial begin
    int fr;
    int svx, svy;
    resetN = 1'b0;
    bus.startOfFrame = 0; bus.launch = 0; bus.speedXIn = 0; bus.speedYIn = 0;
    bus.collision = 0; bus.resetBird = 0;
    model_home();
    repeat (3) @(posedge clk);
    #1;
    check_outputs();
    resetN = 1'b1;
    $display("reset: x=%0d y=%0d state=%0d", bus.topLeftX, bus.topLeftY, bus.state);

    // Frames with no launch keep the bird at rest.
    repeat (3) frame(1'b0);
    check_eq("idle_x", int'(bus.topLeftX), 64);
    check_eq("idle_y", int'(bus.topLeftY), 380);
    check_eq("idle_state", int'(bus.state), 0);
    check_eq("idle_flying", int'(bus.flying), 0);
    $display("idle frames: x=%0d y=%0d", bus.topLeftX, bus.topLeftY);

    // First motion update after a launch.
    tick(1'b0, 1'b1, 64, -160, 1'b0, 1'b0);
    check_eq("flying_after_launch", int'(bus.flying), 1);
    tick(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    check_eq("first_frame_x", int'(bus.topLeftX), 68);
    check_eq("first_frame_y", int'(bus.topLeftY), 370);
    $display("launch 64/-160: x=%0d y=%0d", bus.topLeftX, bus.topLeftY);
    tick(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);

    // Free fall to the ground.
    landed_count = 0;
    tick(1'b0, 1'b1, 0, 0, 1'b0, 1'b0);
    fly_until_stopped(1'b0, fr);
    check_eq("ground_y", int'(bus.topLeftY), 408);
    check_eq("ground_landed_pulses", landed_count, 1);
    $display("drop: landed y=%0d after %0d frames", bus.topLeftY, fr);
    tick(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);

    // Two collision pulses in one frame act once.
    tick(1'b0, 1'b1, 64, 0, 1'b0, 1'b0);
    tick(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
    tick(1'b0, 1'b0, 0, 0, 1'b1, 1'b0);
    tick(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
    check_eq("collision_x", int'(bus.topLeftX), 62);
    frame(1'b0);
    check_eq("collision_once_x", int'(bus.topLeftX), 60);
    $display("collision: x=%0d", bus.topLeftX);
    tick(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);

    // Right edge stop, then launch is ignored.
    tick(1'b0, 1'b1, 512, -160, 1'b0, 1'b0);
    fly_until_stopped(1'b0, fr);
    check_eq("right_edge_x", int'(bus.topLeftX), 608);
    tick(1'b0, 1'b1, 100, -100, 1'b0, 1'b0);
    check_eq("stopped_launch_state", int'(bus.state), 2);
    $display("right edge: x=%0d after %0d frames", bus.topLeftX, fr);

    // resetBird wins over startOfFrame and collision.
    tick(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
    tick(1'b0, 1'b1, 100, -300, 1'b0, 1'b0);
    repeat (5) frame(1'b0);
    tick(1'b1, 1'b1, 0, 0, 1'b1, 1'b1);
    check_eq("resetbird_state", int'(bus.state), 0);
    check_eq("resetbird_x", int'(bus.topLeftX), 64);
    check_eq("resetbird_y", int'(bus.topLeftY), 380);
    $display("resetBird mid-flight: state=%0d", bus.state);

    // Asynchronous reset mid-flight.
    tick(1'b0, 1'b1, -200, -250, 1'b0, 1'b0);
    repeat (5) frame(1'b0);
    resetN = 1'b0;
    #2;
    model_home();
    check_outputs();
    @(posedge clk);
    #1;
    resetN = 1'b1;
    $display("resetN mid-flight: x=%0d y=%0d", bus.topLeftX, bus.topLeftY);

    // Randomized flights with random collisions and stray launches.
    for (int f = 0; f < 14; f++) begin
      svx = int'($urandom_range(0, 1024)) - 512;
      svy = int'($urandom_range(0, 700)) - 550;
      landed_count = 0;
      tick(1'b0, 1'b0, 0, 0, 1'b0, 1'b1);
      tick(1'b0, 1'b1, svx, svy, 1'b0, 1'b0);
      fly_until_stopped(1'b1, fr);
      check_eq("random_landed_pulses", landed_count, 1);
      $display("flight %0d: launch %0d/%0d -> x=%0d y=%0d after %0d frames",
               f, svx, svy, bus.topLeftX, bus.topLeftY, fr);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
